// File: rtl/alu_op_pkg.sv
// Shared ALU operation encodings and the execute-stage state type.
// The operation decoder imports the same constants so both sides agree.
package alu_op_pkg;

  localparam logic [3:0] OpNone   = 4'b0000;
  localparam logic [3:0] OpRRot   = 4'b0001;  // illegal here
  localparam logic [3:0] OpRArith = 4'b0010;  // illegal here
  localparam logic [3:0] OpAnd    = 4'b0011;
  localparam logic [3:0] OpOr     = 4'b0100;
  localparam logic [3:0] OpXor    = 4'b0101;
  localparam logic [3:0] OpAdd    = 4'b0110;
  localparam logic [3:0] OpCmp    = 4'b0111;
  localparam logic [3:0] OpRol    = 4'b1000;
  localparam logic [3:0] OpSll    = 4'b1001;
  localparam logic [3:0] OpRor    = 4'b1010;
  localparam logic [3:0] OpSrl    = 4'b1011;
  localparam logic [3:0] OpInv    = 4'b1100;
  localparam logic [3:0] OpBypass = 4'b1101;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Shift and rotate ops all share the 10xx prefix.
  function automatic logic is_shift_op(logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate step for the iterative shifter.
// Ports: op - operation code; din - working value; dout - value after one step.
module alu_shift_step
  import alu_op_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      OpRol:   dout = {din[WIDTH-2:0], din[WIDTH-1]};
      OpSll:   dout = {din[WIDTH-2:0], 1'b0};
      OpRor:   dout = {din[0], din[WIDTH-1:1]};
      OpSrl:   dout = {1'b0, din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: accepts one decoded op over InValid/InReady, computes
// logic/add/compare in one cycle and shifts/rotates one bit per cycle, then
// presents Result and flags over OutValid/OutReady.
// Ports: clk, rst (sync, active-high); InValid/InReady input handshake;
// ALUOperation, NegA, InvB, A, B operation inputs; OutValid/OutReady output
// handshake; Result, Zero, Cout, Ofl, Err outputs.
module alu_seq_exec
  import alu_op_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUOperation,
  input  logic             NegA,
  input  logic             InvB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Cout,
  output logic             Ofl,
  output logic             Err
);

  state_e             state_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q, ofl_q, err_q, in_ready_q, out_valid_q;

  logic [WIDTH-1:0]   a_p, b_p, res_c, step_out;
  logic [WIDTH:0]     sum;
  logic               cin, cout_c, ofl_c, err_c;
  logic [SHAMT_W-1:0] amt;

  always_comb begin
    a_p    = NegA ? ~A : A;
    b_p    = InvB ? ~B : B;
    amt    = b_p[SHAMT_W-1:0];
    cin    = NegA && (ALUOperation == OpAdd || ALUOperation == OpCmp);
    sum    = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, cin};
    res_c  = '0;
    cout_c = 1'b0;
    ofl_c  = 1'b0;
    err_c  = 1'b0;
    case (ALUOperation)
      OpNone:   res_c = a_p;
      OpAdd, OpCmp: begin
        res_c  = sum[WIDTH-1:0];
        cout_c = sum[WIDTH];
        ofl_c  = (a_p[WIDTH-1] == b_p[WIDTH-1]) && (sum[WIDTH-1] != a_p[WIDTH-1]);
      end
      OpXor:    res_c = a_p ^ b_p;
      OpAnd:    res_c = a_p & b_p;
      OpOr:     res_c = a_p | b_p;
      OpInv:    res_c = ~a_p;
      OpBypass: res_c = b_p;
      // Only reached with a zero shift amount; longer shifts go iterative.
      OpRol, OpSll, OpRor, OpSrl: res_c = a_p;
      default:  err_c = 1'b1;
    endcase
  end

  alu_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op  (op_q),
    .din (work_q),
    .dout(step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpNone;
      work_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ofl_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (InValid) begin
            op_q       <= ALUOperation;
            in_ready_q <= 1'b0;
            if (is_shift_op(ALUOperation) && amt != '0) begin
              work_q  <= a_p;
              cnt_q   <= amt;
              state_q <= StShift;
            end else begin
              result_q    <= res_c;
              cout_q      <= cout_c;
              ofl_q       <= ofl_c;
              err_q       <= err_c;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StShift: begin
          work_q <= step_out;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            result_q    <= step_out;
            cout_q      <= 1'b0;
            ofl_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign Result   = result_q;
  // Flags are qualified by OutValid so they read 0 whenever no result is offered.
  assign Zero     = out_valid_q && (result_q == '0);
  assign Cout     = out_valid_q && cout_q;
  assign Ofl      = out_valid_q && ofl_q;
  assign Err      = out_valid_q && err_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid, InReady;
  logic [3:0]  ALUOperation;
  logic        NegA, InvB;
  logic [15:0] A, B;
  logic        OutValid, OutReady;
  logic [15:0] Result;
  logic        Zero, Cout, Ofl, Err;

  always #5 clk = ~clk;

  alu_seq_exec #(
    .WIDTH  (16),
    .SHAMT_W(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .InValid     (InValid),
    .InReady     (InReady),
    .ALUOperation(ALUOperation),
    .NegA        (NegA),
    .InvB        (InvB),
    .A           (A),
    .B           (B),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Result      (Result),
    .Zero        (Zero),
    .Cout        (Cout),
    .Ofl         (Ofl),
    .Err         (Err)
  );

  typedef struct {
    logic [15:0] res;
    logic        zero, cout, ofl, err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: timestamps accepts and checks each offered result against the queue.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      acc_q.delete();
    end else begin
      if (InValid && InReady) acc_q.push_back(cyc);
      if (OutValid && !prev_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_out", {31'd0, OutValid}, 32'd0);
        end else begin
          chk("latency", cyc - acc_q.pop_front(), exp_q[0].lat);
        end
      end
      if (OutValid && OutReady && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", {16'd0, Result}, {16'd0, e.res});
        chk("zero", {31'd0, Zero}, {31'd0, e.zero});
        chk("cout", {31'd0, Cout}, {31'd0, e.cout});
        chk("ofl", {31'd0, Ofl}, {31'd0, e.ofl});
        chk("err", {31'd0, Err}, {31'd0, e.err});
      end
    end
    prev_valid = OutValid && !rst;
  end

  task automatic issue(input logic [3:0] op, input logic na, input logic ib,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                       input logic z, input logic co, input logic of, input logic er,
                       input int lat, input bit expect_out);
    int n = 0;
    if (expect_out) begin
      exp_t e;
      e.res = res; e.zero = z; e.cout = co; e.ofl = of; e.err = er; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ALUOperation = op; NegA = na; InvB = ib; A = a; B = b; InValid = 1'b1;
    @(negedge clk);
    while (!InReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!InReady) begin
      $display("FAIL accept_timeout: got InReady=0 want 1");
      bad++; total++;
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    A = 16'hDEAD; B = 16'hBEEF;  // changes while busy must not matter
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL done_timeout: got pending=%0d want 0", exp_q.size());
      bad++; total++;
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [3:0] op, input logic na, input logic ib,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                     input logic co, input logic of, input logic er, input int lat);
    issue(op, na, ib, a, b, res, (res == 16'h0), co, of, er, lat, 1'b1);
    wait_done();
  endtask

  initial begin
    int n;
    rst = 1'b1; InValid = 1'b0; OutReady = 1'b1; ALUOperation = 4'h0;
    NegA = 1'b0; InvB = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_inready", {31'd0, InReady}, 32'd1);
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_result", {16'd0, Result}, 32'd0);
    chk("rst_flags", {28'd0, Zero, Cout, Ofl, Err}, 32'd0);

    //  op      NegA InvB A         B         Result    Cout Ofl  Err  lat
    run(4'b0110, 0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1);
    run(4'b0110, 1, 0, 16'h0005, 16'h0003, 16'hFFFE, 0, 0, 0, 1);
    run(4'b0110, 1, 0, 16'h0003, 16'h0005, 16'h0002, 1, 0, 0, 1);
    run(4'b0111, 1, 0, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 1);
    run(4'b1000, 0, 0, 16'h8001, 16'h0004, 16'h0018, 0, 0, 0, 5);
    run(4'b1011, 0, 0, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 1);
    run(4'b1001, 0, 0, 16'h0001, 16'h0003, 16'h0008, 0, 0, 0, 4);
    run(4'b1010, 0, 0, 16'h0001, 16'h0001, 16'h8000, 0, 0, 0, 2);
    run(4'b1011, 0, 0, 16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 16);
    run(4'b1100, 1, 0, 16'h00FF, 16'h0000, 16'h00FF, 0, 0, 0, 1);
    run(4'b0011, 0, 0, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 1);
    run(4'b0100, 0, 0, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0, 1);
    run(4'b0000, 1, 0, 16'h00FF, 16'h0000, 16'hFF00, 0, 0, 0, 1);
    run(4'b0010, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1, 1);
    run(4'b1101, 0, 1, 16'h0000, 16'h00AA, 16'hFF55, 0, 0, 0, 1);

    // Backpressure: XOR held in DONE while OutReady is low.
    OutReady = 1'b0;
    issue(4'b0101, 0, 0, 16'hFF00, 16'h0FF0, 16'hF0F0, 0, 0, 0, 0, 1, 1'b1);
    n = 0;
    while (!OutValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_result", {16'd0, Result}, 32'h0000F0F0);
      chk("bp_outvalid", {31'd0, OutValid}, 32'd1);
      chk("bp_inready", {31'd0, InReady}, 32'd0);
    end
    @(posedge clk); #1 OutReady = 1'b1;
    wait_done();
    @(negedge clk);
    chk("bp_release_outvalid", {31'd0, OutValid}, 32'd0);
    chk("bp_release_inready", {31'd0, InReady}, 32'd1);

    // Reset during cycle 3 of an SLL by 8: result must be dropped.
    issue(4'b1001, 0, 0, 16'h00FF, 16'h0008, 16'h0, 0, 0, 0, 0, 0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outvalid", {31'd0, OutValid}, 32'd0);
    chk("abort_result", {16'd0, Result}, 32'd0);
    chk("abort_inready", {31'd0, InReady}, 32'd1);
    repeat (15) @(negedge clk);
    chk("abort_no_stale", {31'd0, OutValid}, 32'd0);

    run(4'b0101, 0, 0, 16'hAAAA, 16'hAAAA, 16'h0000, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Execution-side consumer of the decoded ALU control word (ALUOperation, NegA, InvB) produced by the ALU operation decoder. It accepts one operation and its operands over a valid/ready handshake. Logic, add and compare operations complete in one cycle. Shift and rotate operations run iteratively, one bit per cycle. The block sits in the execute stage and returns its result and flags over a second valid/ready handshake.

Parameters:
WIDTH, 16, datapath width in bits.
SHAMT_W, 4, shift-amount width; equals log2(WIDTH).

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-high.
InValid  input  1  operation and operands are present.
InReady  output  1  block can accept an operation.
ALUOperation  input  4  decoded operation code.
NegA  input  1  negate A (two's complement for ADD/CMP, bitwise for other ops).
InvB  input  1  bitwise-invert B before use.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B; B'[SHAMT_W-1:0] is the shift amount.
OutValid  output  1  result is valid.
OutReady  input  1  consumer accepts the result.
Result  output  WIDTH  operation result.
Zero  output  1  Result == 0.
Cout  output  1  carry out; ADD/CMP only, else 0.
Ofl  output  1  signed overflow; ADD/CMP only, else 0.
Err  output  1  illegal ALUOperation was accepted.

Behaviour:
- Reset (synchronous, active-high): state IDLE; InReady=1; OutValid=0; Result, Zero, Cout, Ofl, Err all 0. A reset asserted during SHIFT or DONE aborts the operation, and the result is dropped.
- Operand preparation at accept:
  - B' = InvB ? ~B : B.
  - A' = NegA ? ~A : A.
  - cin = NegA, applied for ADD/CMP only.
- Operation encodings:
  - 0000 NONE: Result = A'.
  - 0110 ADD and 0111 CMP: {Cout,Result} = A' + B' + cin. Ofl is set when A'[MSB] == B'[MSB] and Result[MSB] differs from them.
  - 0101 XOR: A'^B'. 0011 AND: A'&B'. 0100 OR: A'|B'.
  - 1100 INV: ~A'.
  - 1101 BYPASS: B'.
  - 1000 ROL, 1001 SLL, 1010 ROR, 1011 SRL: shift or rotate A' by B'[SHAMT_W-1:0]. Logical shifts fill with 0.
  - 0001, 0010, 1110, 1111 are illegal: Result = 0, Err = 1, Zero = 1.
- State machine: IDLE, SHIFT, DONE.
  - IDLE: InReady=1. A handshake (InValid & InReady) latches A', B', the op and the amount.
    - Shift op with amount > 0: go to SHIFT; the counter loads the amount.
    - Any other op, or amount = 0: compute Result, go to DONE.
  - SHIFT: InReady=0. Each cycle the working register shifts or rotates by 1 and the counter decrements. When the counter reaches 1, that final step is taken and the state goes to DONE.
  - DONE: OutValid=1; Result and flags are held stable. When OutReady=1, go to IDLE and drop OutValid the next cycle. InReady=0 in DONE; there is no same-cycle accept.
- Latency, counted from the accept edge:
  - Non-shift ops: OutValid on the following cycle (1 cycle).
  - Shift ops: 1 + amount cycles; amount = 0 gives 1 cycle.
  - Minimum throughput: one operation per 2 cycles.
- Zero is computed from the final Result. Err is valid only while OutValid=1; otherwise it is 0.
- Inputs are ignored outside IDLE. Operand changes while busy have no effect.

Decomposition:
- Shared package alu_op_pkg:
  - 4-bit ALU operation constants: NONE, R_ROT, R_ARITH, ADD, XOR, AND, OR, CMP, ROL, SLL, ROR, SRL, BYPASS, INV.
  - State encoding typedef for IDLE, SHIFT and DONE.
  - The decoder must use the same constants.
- Sub-module alu_shift_step: combinational shift or rotate by one bit for the four shift ops. It is instantiated once in the iterative loop.

Test Plan:
1. ADD: NegA=0, InvB=0, A=0x7FFF, B=0x0001 -> one cycle after accept, Result=0x8000, Ofl=1, Cout=0, Zero=0, Err=0.
2. Subtract via ADD: NegA=1, A=0x0005, B=0x0003 -> Result=0xFFFE, Cout=0, Ofl=0. Then A=0x0003, B=0x0005 -> Result=0x0002, Cout=1.
3. ROL: A=0x8001, B=0x0004 -> InReady low for 5 cycles, OutValid 5 cycles after accept, Result=0x0018. SRL with B=0x0000 and A=0x1234 -> Result=0x1234 after 1 cycle.
4. Backpressure: complete an XOR with A=0xFF00, B=0x0FF0 while OutReady=0 for 3 cycles -> Result=0xF0F0 stable, OutValid=1, InReady=0 throughout. OutReady=1 -> IDLE next cycle.
5. Illegal op 0010 with A=0xFFFF -> Result=0x0000, Err=1, Zero=1. The next legal BYPASS with B=0x00AA and InvB=1 -> Result=0xFF55, Err=0.
6. Reset mid-operation: assert rst during cycle 3 of an SLL by 8 -> next cycle IDLE, OutValid=0, Result=0, InReady=1. No stale result appears afterward.
